// File: rtl/ms_ram_arb_pkg.sv
// ms_ram_arb_pkg
//   Shared definitions for the data-RAM arbiter:
//   - bus field widths of the 64-bit data-RAM port (word address [31:3],
//     64-bit data, 8 byte lanes)
//   - TRrPick / RrPick: round-robin pick (rotate, find-first, un-rotate) for
//     up to CMaxMst requesters. Other arbiters can reuse it.
package ms_ram_arb_pkg;

  localparam int CAddrW   = 29;  // word address [31:3]
  localparam int CDataW   = 64;
  localparam int CBeW     = 8;   // one enable bit per byte lane
  localparam int CMaxMst  = 8;   // widest requester vector RrPick handles
  localparam int CMaxPtrW = 3;   // $clog2(CMaxMst)

  typedef struct packed {
    logic                found;
    logic [CMaxPtrW-1:0] idx;
  } TRrPick;

  // Returns the first requester at or after rrPtr, wrapping at mstCnt.
  // rrPtr must be below mstCnt. With no request: found=0, idx=0.
  function automatic TRrPick RrPick(input logic [CMaxMst-1:0]  req,
                                    input logic [CMaxPtrW-1:0] rrPtr,
                                    input int                  mstCnt);
    TRrPick                pick;
    logic   [CMaxMst-1:0]  rot;
    int                    src;
    pick = '0;
    rot  = '0;
    // Rotate so that the requester at rrPtr sits at bit 0.
    for (int k = 0; k < CMaxMst; k++) begin
      if (k < mstCnt) begin
        src = int'(rrPtr) + k;
        if (src >= mstCnt) src = src - mstCnt;
        rot[k] = req[src];
      end
    end
    // Find the first set bit. The loop runs downward, so the lowest set bit
    // is the one that survives. Then map it back to a master index.
    for (int k = CMaxMst - 1; k >= 0; k--) begin
      if (rot[k]) begin
        src = int'(rrPtr) + k;
        if (src >= mstCnt) src = src - mstCnt;
        pick.found = 1'b1;
        pick.idx   = CMaxPtrW'(src);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ms_ram_arb_if.sv
// ms_ram_arb_if
//   Bus bundle between the CMstCnt masters, the arbiter and the data RAM.
//   Per-master fields are flattened: master i occupies slice [i*W +: W].
//   modport slave  : arbiter view (master requests in, RAM port out)
//   modport master : environment view (masters + RAM macro)
//   Signals:
//     AMstAddr/AMstMosi/AMstWrEn/AMstRdEn  per-master request
//     AMstMiso/AMstRdVld/AMstBusy          per-master response
//     ARamAddr/ARamMosi/ARamWrEn/ARamRdEn  shared RAM request
//     ARamMiso                             RAM read data (1-cycle latency)
interface ms_ram_arb_if
  import ms_ram_arb_pkg::*;
#(
  parameter int CMstCnt = 3
);

  logic [CMstCnt*CAddrW-1:0] AMstAddr;
  logic [CMstCnt*CDataW-1:0] AMstMosi;
  logic [CMstCnt*CBeW-1:0]   AMstWrEn;
  logic [CMstCnt*CBeW-1:0]   AMstRdEn;
  logic [CMstCnt*CDataW-1:0] AMstMiso;
  logic [CMstCnt-1:0]        AMstRdVld;
  logic [CMstCnt-1:0]        AMstBusy;

  logic [CAddrW-1:0]         ARamAddr;
  logic [CDataW-1:0]         ARamMosi;
  logic [CBeW-1:0]           ARamWrEn;
  logic [CBeW-1:0]           ARamRdEn;
  logic [CDataW-1:0]         ARamMiso;

  modport slave (
    input  AMstAddr, AMstMosi, AMstWrEn, AMstRdEn, ARamMiso,
    output AMstMiso, AMstRdVld, AMstBusy,
    output ARamAddr, ARamMosi, ARamWrEn, ARamRdEn
  );

  modport master (
    output AMstAddr, AMstMosi, AMstWrEn, AMstRdEn, ARamMiso,
    input  AMstMiso, AMstRdVld, AMstBusy,
    input  ARamAddr, ARamMosi, ARamWrEn, ARamRdEn
  );

endinterface

// File: rtl/ms_rr_pick.sv
// ms_rr_pick
//   Combinational round-robin priority encoder.
//   AReq    in  CMstCnt  request vector
//   APtr    in  CPtrW    highest-priority index (must be < CMstCnt)
//   AWinner out CPtrW    granted index (0 when AFound=0)
//   AFound  out 1        at least one request present
module ms_rr_pick
  import ms_ram_arb_pkg::*;
#(
  parameter int CMstCnt = 3,
  parameter int CPtrW   = 3
) (
  input  logic [CMstCnt-1:0] AReq,
  input  logic [CPtrW-1:0]   APtr,
  output logic [CPtrW-1:0]   AWinner,
  output logic               AFound
);

  TRrPick pick;

  always_comb begin
    pick    = RrPick(CMaxMst'(AReq), CMaxPtrW'(APtr), CMstCnt);
    AFound  = pick.found;
    AWinner = CPtrW'(pick.idx);
  end

endmodule

// File: rtl/ms_ram_arb.sv
// ms_ram_arb
//   Round-robin arbiter that shares one 64-bit data-RAM port between
//   CMstCnt masters (cores, debug loader, DMA).
//   AClkH    in  system clock
//   AResetHN in  asynchronous active-low reset
//   AClkHEn  in  clock enable; state advances only when 1
//   ABus     slave modport of ms_ram_arb_if (master requests/responses and
//            the shared RAM port)
//   Each enabled cycle, one requester is granted and drives the RAM port in
//   the same cycle. The other requesters see AMstBusy and must hold their
//   request. Read data returns one enabled cycle later and goes only to the
//   master that issued the read.
module ms_ram_arb
  import ms_ram_arb_pkg::*;
#(
  parameter int CMstCnt = 3,
  parameter int CPtrW   = 3
) (
  input  logic         AClkH,
  input  logic         AResetHN,
  input  logic         AClkHEn,
  ms_ram_arb_if.slave  ABus
);

  logic [CMstCnt-1:0] req;
  logic [CPtrW-1:0]   winner;
  logic               found;
  logic               grant;
  logic [CPtrW-1:0]   nextPtr;

  logic [CAddrW-1:0]  selAddr;
  logic [CDataW-1:0]  selMosi;
  logic [CBeW-1:0]    selWrEn;
  logic [CBeW-1:0]    selRdEn;

  logic [CPtrW-1:0]   rrPtr;
  logic [CPtrW-1:0]   rdOwn;
  logic               rdPend;
  logic [CMstCnt-1:0] rdVld;

  // A master requests when any byte lane is enabled for read or write.
  // NOTE: every signal written in an always_comb gets a default before the
  // loop/branches; a path that leaves a signal unassigned infers a latch.
  always_comb begin
    req = '0;
    for (int i = 0; i < CMstCnt; i++) begin
      req[i] = (|ABus.AMstWrEn[i*CBeW +: CBeW]) | (|ABus.AMstRdEn[i*CBeW +: CBeW]);
    end
  end

  ms_rr_pick #(
    .CMstCnt (CMstCnt),
    .CPtrW   (CPtrW)
  ) uPick (
    .AReq    (req),
    .APtr    (rrPtr),
    .AWinner (winner),
    .AFound  (found)
  );

  // Winner's fields, selected by a decoded compare so that no index ever
  // points past the last master.
  always_comb begin
    selAddr = '0;
    selMosi = '0;
    selWrEn = '0;
    selRdEn = '0;
    for (int i = 0; i < CMstCnt; i++) begin
      if (winner == CPtrW'(i)) begin
        selAddr = ABus.AMstAddr[i*CAddrW +: CAddrW];
        selMosi = ABus.AMstMosi[i*CDataW +: CDataW];
        selWrEn = ABus.AMstWrEn[i*CBeW +: CBeW];
        selRdEn = ABus.AMstRdEn[i*CBeW +: CBeW];
      end
    end
  end

  // A grant only reaches the RAM when the clock is enabled and reset is
  // released. Otherwise every requester is stalled.
  assign grant = found & AClkHEn & AResetHN;

  always_comb begin
    ABus.ARamAddr = grant ? selAddr : '0;
    ABus.ARamMosi = grant ? selMosi : '0;
    ABus.ARamWrEn = grant ? selWrEn : '0;
    ABus.ARamRdEn = grant ? selRdEn : '0;
    ABus.AMstBusy = '0;
    for (int i = 0; i < CMstCnt; i++) begin
      ABus.AMstBusy[i] = req[i] & ~(grant & (winner == CPtrW'(i)));
    end
  end

  assign nextPtr = (winner == CPtrW'(CMstCnt - 1)) ? '0 : winner + CPtrW'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      rrPtr  <= '0;
      rdOwn  <= '0;
      rdPend <= 1'b0;
    end else if (AClkHEn) begin
      if (found) rrPtr <= nextPtr;
      rdPend <= found & (|selRdEn);
      rdOwn  <= winner;
    end
  end

  // Read return: RAM data goes to the owner of the previous read grant. All
  // other masters see zero.
  always_comb begin
    rdVld         = '0;
    ABus.AMstMiso = '0;
    for (int i = 0; i < CMstCnt; i++) begin
      rdVld[i] = rdPend & (rdOwn == CPtrW'(i));
      ABus.AMstMiso[i*CDataW +: CDataW] = rdVld[i] ? ABus.ARamMiso : '0;
    end
    ABus.AMstRdVld = rdVld;
  end

endmodule

// File: tb/tb_ms_ram_arb.sv
// tb_ms_ram_arb
//   Self-checking bench for ms_ram_arb with 3 masters. The stimulus side
//   keeps a plain round-robin model of the arbiter and pushes the expected
//   RAM-port grants and read returns into queues. A monitor pops from those
//   queues whenever the DUT drives the RAM port or raises a read valid.
//   The RAM is modelled as returning a fixed function of the address, one
//   enabled cycle after a read.
module tb_ms_ram_arb;
  import ms_ram_arb_pkg::*;

  localparam int N  = 3;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rstN;
  logic clkEn;

  ms_ram_arb_if #(.CMstCnt(N)) bus();

  ms_ram_arb #(
    .CMstCnt (N),
    .CPtrW   (PW)
  ) dut (
    .AClkH    (clk),
    .AResetHN (rstN),
    .AClkHEn  (clkEn),
    .ABus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [28:0] addr;
    logic [63:0] mosi;
    logic [7:0]  wr;
    logic [7:0]  rd;
  } TGnt;

  typedef struct {
    int          mst;
    logic [63:0] data;
  } TRd;

  TGnt gntQ[$];
  TRd  rdQ[$];

  // Pending request per master. A master requests while wr or rd is nonzero.
  logic [28:0] pAddr[N];
  logic [63:0] pMosi[N];
  logic [7:0]  pWr[N];
  logic [7:0]  pRd[N];
  int          rrPtr;

  // RAM model: each address returns a fixed, address-dependent word.
  logic [63:0] ramMiso = '0;

  function automatic logic [63:0] ramData(input logic [28:0] a);
    return {6'h2A, a, a ^ 29'h1555_5555};
  endfunction

  always @(posedge clk) begin
    if (clkEn && bus.ARamRdEn != 8'h00) ramMiso <= ramData(bus.ARamAddr);
  end
  assign bus.ARamMiso = ramMiso;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit isReq(input int i);
    return (pWr[i] != 8'h00) || (pRd[i] != 8'h00);
  endfunction

  // Reference: the first requester at or after the pointer, wrapping around.
  function automatic int pickModel();
    for (int k = 0; k < N; k++) begin
      int m;
      m = (rrPtr + k) % N;
      if (isReq(m)) return m;
    end
    return -1;
  endfunction

  task automatic drive();
    logic [N*29-1:0] a;
    logic [N*64-1:0] d;
    logic [N*8-1:0]  w;
    logic [N*8-1:0]  r;
    for (int i = 0; i < N; i++) begin
      a[i*29 +: 29] = pAddr[i];
      d[i*64 +: 64] = pMosi[i];
      w[i*8 +: 8]   = pWr[i];
      r[i*8 +: 8]   = pRd[i];
    end
    bus.AMstAddr = a;
    bus.AMstMosi = d;
    bus.AMstWrEn = w;
    bus.AMstRdEn = r;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < N; i++) begin
      pAddr[i] = '0;
      pMosi[i] = '0;
      pWr[i]   = '0;
      pRd[i]   = '0;
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input bit en);
    int          w;
    logic [N-1:0] expBusy;
    clkEn = en;
    drive();
    w = en ? pickModel() : -1;
    for (int i = 0; i < N; i++) expBusy[i] = isReq(i) && (i != w);
    if (w >= 0) begin
      gntQ.push_back('{pAddr[w], pMosi[w], pWr[w], pRd[w]});
      if (pRd[w] != 8'h00) rdQ.push_back('{w, ramData(pAddr[w])});
    end
    @(negedge clk);
    check("busy", {253'd0, bus.AMstBusy}, {253'd0, expBusy});
    @(posedge clk);
    if (w >= 0) begin
      rrPtr = (w + 1) % N;
      pWr[w] = '0;
      pRd[w] = '0;
    end
    #1;
  endtask

  task automatic setRead(input int m);
    pAddr[m] = 29'($urandom);
    pMosi[m] = '0;
    pWr[m]   = '0;
    pRd[m]   = 8'hFF;
  endtask

  // Monitor: compares every RAM-port transaction and every qualified read
  // return against the queues.
  TGnt             mGnt;
  TRd              mRd;
  logic [N-1:0]    mExpVld;
  logic [N*64-1:0] mExpMiso;

  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (bus.ARamWrEn != 8'h00 || bus.ARamRdEn != 8'h00) begin
        if (gntQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_port: got addr %0h wr %0h rd %0h expected no grant",
                   bus.ARamAddr, bus.ARamWrEn, bus.ARamRdEn);
        end else begin
          mGnt = gntQ.pop_front();
          check("ram_port", {134'd0, bus.ARamAddr, bus.ARamMosi, bus.ARamWrEn, bus.ARamRdEn},
                {134'd0, mGnt.addr, mGnt.mosi, mGnt.wr, mGnt.rd});
        end
      end
      if (clkEn === 1'b1 && bus.AMstRdVld != '0) begin
        if (rdQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_vld: got %0h expected no read return", bus.AMstRdVld);
        end else begin
          mRd = rdQ.pop_front();
          mExpVld = '0;
          mExpVld[mRd.mst] = 1'b1;
          mExpMiso = '0;
          mExpMiso[mRd.mst*64 +: 64] = mRd.data;
          check("rd_vld", {253'd0, bus.AMstRdVld}, {253'd0, mExpVld});
          check("rd_miso", {64'd0, bus.AMstMiso}, {64'd0, mExpMiso});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected run completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstN  = 1'b1;
    clkEn = 1'b0;
    rrPtr = 0;
    clearReqs();
    drive();
    #1 rstN = 1'b0;
    #11;
    // Reset state with no requests.
    check("rst_busy", {253'd0, bus.AMstBusy}, 256'd0);
    check("rst_rdvld", {253'd0, bus.AMstRdVld}, 256'd0);
    check("rst_ram", {134'd0, bus.ARamAddr, bus.ARamMosi, bus.ARamWrEn, bus.ARamRdEn}, 256'd0);
    @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;

    // All three masters read continuously from reset: grants 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!isReq(i)) setRead(i);
      step(1'b1);
    end
    clearReqs();
    step(1'b1);

    // Single write from master 1 passes straight through.
    rrPtr = 0;
    rstN  = 1'b0;
    #1 rstN = 1'b1;
    pAddr[1] = 29'h100;
    pWr[1]   = 8'hFF;
    pMosi[1] = 64'h1122_3344_5566_7788;
    step(1'b1);
    // Pointer now 2: with everyone requesting, master 2 wins first.
    for (int i = 0; i < N; i++) setRead(i);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Master 2 alone, back-to-back reads.
    setRead(2);
    step(1'b1);
    setRead(2);
    step(1'b1);
    step(1'b1);

    // Clock enable low for 3 cycles with masters 0 and 1 requesting.
    setRead(0);
    pAddr[1] = 29'h0ABC;
    pWr[1]   = 8'h3C;
    pMosi[1] = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Pointer to 1, then master 1 write (0x0F) against master 0 read.
    setRead(0);
    step(1'b1);
    setRead(0);
    pAddr[1] = 29'h1234;
    pWr[1]   = 8'h0F;
    pMosi[1] = 64'hDEAD_BEEF_0BAD_F00D;
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Asynchronous reset with a read in flight.
    setRead(2);
    step(1'b1);
    check("rdvld_inflight", {253'd0, bus.AMstRdVld}, {253'd0, 3'b100});
    pAddr[0] = 29'h77;
    pRd[0]   = 8'h0F;
    drive();
    clkEn = 1'b1;
    #1 rstN = 1'b0;
    rdQ.delete();
    gntQ.delete();
    rrPtr = 0;
    #1;
    check("rst_async_rdvld", {253'd0, bus.AMstRdVld}, 256'd0);
    check("rst_async_ram_en", {240'd0, bus.ARamWrEn, bus.ARamRdEn}, 256'd0);
    check("rst_async_busy", {253'd0, bus.AMstBusy}, {253'd0, 3'b001});
    @(posedge clk);
    #1;
    check("rst_hold_rdvld", {253'd0, bus.AMstRdVld}, 256'd0);
    clearReqs();
    drive();
    @(posedge clk);
    #2 rstN = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1);
    check("no_stray_vld", {253'd0, bus.AMstRdVld}, 256'd0);
    // Pointer restarted at 0.
    for (int i = 0; i < N; i++) setRead(i);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Randomized traffic with occasional clock-enable gaps.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!isReq(i) && $urandom_range(0, 1) == 1) begin
          int kind;
          kind     = int'($urandom_range(0, 2));
          pAddr[i] = 29'($urandom);
          pMosi[i] = {$urandom, $urandom};
          pWr[i]   = (kind != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
          pRd[i]   = (kind != 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
      end
      step($urandom_range(0, 9) != 0);
    end
    clearReqs();
    step(1'b1);
    step(1'b1);

    check("gnt_queue_empty", 256'(gntQ.size()), 256'd0);
    check("rd_queue_empty", 256'(rdQ.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
